// File: rtl/ast_width_upsizer_pkg.sv
// rtl/ast_width_upsizer_pkg.sv - shared types and helpers for the Avalon-ST width upsizer
// Purpose: FSM state encoding and a width helper used by the upsizer and its output register.
// Ports: none (package).
package ast_width_upsizer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no open packet
    PKT  = 2'd1,  // packet open, accumulator may hold words
    HOLD = 2'd2   // a single-word sop/eop beat waits behind a flushed beat
  } state_e;

  // Width needed to count 0..value-1, never less than one bit.
  function automatic int clog2_min1(input int value);
    return (value > 2) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/ast_width_upsizer_out_reg.sv
// rtl/ast_width_upsizer_out_reg.sv - output beat holding register with load/stall control
// Purpose: holds one output beat; loads on load_i, clears valid on downstream accept.
// Ports: clk_i/rst_ni clock and async active-low reset; load_i plus *_i beat fields in;
//        ready_i downstream accept; valid_o plus *_o registered beat fields out.
module ast_width_upsizer_out_reg #(
  parameter int DATA_W    = 128,
  parameter int EMPTY_W   = 4,
  parameter int CHANNEL_W = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic                 ready_i,
  input  logic [DATA_W-1:0]    data_i,
  input  logic                 sop_i,
  input  logic                 eop_i,
  input  logic [EMPTY_W-1:0]   empty_i,
  input  logic [CHANNEL_W-1:0] channel_i,
  output logic                 valid_o,
  output logic [DATA_W-1:0]    data_o,
  output logic                 sop_o,
  output logic                 eop_o,
  output logic [EMPTY_W-1:0]   empty_o,
  output logic [CHANNEL_W-1:0] channel_o
);

  logic                 valid_q, valid_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 sop_q, sop_d;
  logic                 eop_q, eop_d;
  logic [EMPTY_W-1:0]   empty_q, empty_d;
  logic [CHANNEL_W-1:0] channel_q, channel_d;

  // The upstream only asserts load_i when the register is free, so a load
  // never overwrites a beat the downstream has not taken yet.
  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    sop_d     = sop_q;
    eop_d     = eop_q;
    empty_d   = empty_q;
    channel_d = channel_q;
    if (load_i) begin
      valid_d   = 1'b1;
      data_d    = data_i;
      sop_d     = sop_i;
      eop_d     = eop_i;
      empty_d   = empty_i;
      channel_d = channel_i;
    end else if (ready_i) begin
      valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      empty_q   <= '0;
      channel_q <= '0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      empty_q   <= empty_d;
      channel_q <= channel_d;
    end
  end

  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign sop_o     = sop_q;
  assign eop_o     = eop_q;
  assign empty_o   = empty_q;
  assign channel_o = channel_q;

endmodule

// File: rtl/ast_width_upsizer.sv
// rtl/ast_width_upsizer.sv - Avalon-ST packet width upsizer, RATIO input words per output beat
// Purpose: packs DATA_OUT_W/DATA_IN_W words (first word most significant) into one beat,
//          carrying sop/eop/empty/channel, recovering from missing sop or missing eop.
// Ports: clk_i, rst_ni (async active-low); ast_*_i input stream with ast_ready_o;
//        ast_*_o output stream with ast_ready_i; err_o one-cycle framing error pulse.
module ast_width_upsizer
  import ast_width_upsizer_pkg::*;
#(
  parameter int DATA_IN_W   = 64,
  parameter int DATA_OUT_W  = 128,
  parameter int CHANNEL_W   = 10,
  parameter int EMPTY_IN_W  = clog2_min1(DATA_IN_W / 8),
  parameter int EMPTY_OUT_W = clog2_min1(DATA_OUT_W / 8)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [DATA_IN_W-1:0]   ast_data_i,
  input  logic                   ast_startofpacket_i,
  input  logic                   ast_endofpacket_i,
  input  logic                   ast_valid_i,
  input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
  input  logic [CHANNEL_W-1:0]   ast_channel_i,
  output logic                   ast_ready_o,
  output logic [DATA_OUT_W-1:0]  ast_data_o,
  output logic                   ast_startofpacket_o,
  output logic                   ast_endofpacket_o,
  output logic                   ast_valid_o,
  output logic [EMPTY_OUT_W-1:0] ast_empty_o,
  output logic [CHANNEL_W-1:0]   ast_channel_o,
  input  logic                   ast_ready_i,
  output logic                   err_o
);

  localparam int RATIO    = DATA_OUT_W / DATA_IN_W;
  localparam int IDX_W    = clog2_min1(RATIO);
  localparam int BYTES_IN = DATA_IN_W / 8;
  localparam int PAD_W    = DATA_OUT_W - DATA_IN_W;

  typedef logic [DATA_IN_W-1:0]   word_t;
  typedef logic [CHANNEL_W-1:0]   channel_t;
  typedef logic [EMPTY_IN_W-1:0]  empty_in_t;
  typedef logic [EMPTY_OUT_W-1:0] empty_out_t;

  if ((DATA_OUT_W % DATA_IN_W) != 0 || RATIO < 2 || (DATA_IN_W % 8) != 0) begin : g_bad_params
    $error("ast_width_upsizer: DATA_OUT_W must be an integer multiple >= 2 of DATA_IN_W (a multiple of 8)");
  end

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  word_t             acc_q [RATIO-1];
  word_t             acc_d [RATIO-1];
  channel_t          ch_q, ch_d;
  logic              first_q, first_d;       // next beat of the open packet carries sop
  empty_in_t         hold_empty_q, hold_empty_d;
  logic              err_q, err_d;

  logic                  out_free, ready, in_fire, load;
  logic [DATA_OUT_W-1:0] acc_beat, in_beat, beat_data;
  logic                  beat_sop, beat_eop;
  empty_out_t            beat_empty;
  channel_t              beat_ch;

  assign out_free    = !ast_valid_o || ast_ready_i;
  assign ready       = out_free && (state_q != HOLD) && rst_ni;
  assign ast_ready_o = ready;
  assign in_fire     = ast_valid_i && ready;
  assign err_o       = err_q;

  // Unused bytes when the last valid word sits in lane last_lane.
  function automatic empty_out_t eop_empty(input int last_lane, input empty_in_t e);
    return empty_out_t'((RATIO - 1 - last_lane) * BYTES_IN) + empty_out_t'(e);
  endfunction

  // acc_beat: the words already collected in their lanes; in_beat: the incoming
  // word placed in lane idx_q. Lanes at or beyond idx_q stay zero in acc_beat.
  always_comb begin
    acc_beat = '0;
    for (int k = 0; k < RATIO - 1; k++) begin
      if (k < int'(idx_q)) begin
        acc_beat[DATA_OUT_W-1-k*DATA_IN_W -: DATA_IN_W] = acc_q[k];
      end
    end
    in_beat = {ast_data_i, {PAD_W{1'b0}}} >> (int'(idx_q) * DATA_IN_W);
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    ch_d         = ch_q;
    first_d      = first_q;
    hold_empty_d = hold_empty_q;
    err_d        = 1'b0;
    load         = 1'b0;
    beat_data    = '0;
    beat_sop     = 1'b0;
    beat_eop     = 1'b0;
    beat_empty   = '0;
    beat_ch      = '0;

    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          if (!ast_startofpacket_i) begin
            err_d = 1'b1;
          end else if (ast_endofpacket_i) begin
            load       = 1'b1;
            beat_data  = {ast_data_i, {PAD_W{1'b0}}};
            beat_sop   = 1'b1;
            beat_eop   = 1'b1;
            beat_empty = eop_empty(0, ast_empty_i);
            beat_ch    = ast_channel_i;
          end else begin
            acc_d[0] = ast_data_i;
            idx_d    = IDX_W'(1);
            ch_d     = ast_channel_i;
            first_d  = 1'b1;
            state_d  = PKT;
          end
        end
      end

      PKT: begin
        if (in_fire && ast_startofpacket_i) begin
          // Missing eop: close what we have, then start over on this word.
          // With idx_q == 0 every earlier word already left in a full beat.
          err_d = 1'b1;
          if (idx_q != '0) begin
            load       = 1'b1;
            beat_data  = acc_beat;
            beat_sop   = first_q;
            beat_eop   = 1'b1;
            beat_empty = eop_empty(int'(idx_q) - 1, '0);
            beat_ch    = ch_q;
          end
          ch_d  = ast_channel_i;
          idx_d = '0;
          if (ast_endofpacket_i) begin
            if (idx_q != '0) begin
              // Output register is taken by the flush; park the word.
              acc_d[0]     = ast_data_i;
              hold_empty_d = ast_empty_i;
              state_d      = HOLD;
            end else begin
              load       = 1'b1;
              beat_data  = {ast_data_i, {PAD_W{1'b0}}};
              beat_sop   = 1'b1;
              beat_eop   = 1'b1;
              beat_empty = eop_empty(0, ast_empty_i);
              beat_ch    = ast_channel_i;
              state_d    = IDLE;
            end
          end else begin
            acc_d[0] = ast_data_i;
            idx_d    = IDX_W'(1);
            first_d  = 1'b1;
          end
        end else if (in_fire) begin
          if (idx_q == IDX_W'(RATIO - 1) || ast_endofpacket_i) begin
            load       = 1'b1;
            beat_data  = acc_beat | in_beat;
            beat_sop   = first_q;
            beat_eop   = ast_endofpacket_i;
            beat_empty = ast_endofpacket_i ? eop_empty(int'(idx_q), ast_empty_i) : '0;
            beat_ch    = ch_q;
            idx_d      = '0;
            first_d    = 1'b0;
            if (ast_endofpacket_i) begin
              state_d = IDLE;
            end
          end else begin
            for (int k = 0; k < RATIO - 1; k++) begin
              if (k == int'(idx_q)) begin
                acc_d[k] = ast_data_i;
              end
            end
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      HOLD: begin
        if (out_free) begin
          load       = 1'b1;
          beat_data  = {acc_q[0], {PAD_W{1'b0}}};
          beat_sop   = 1'b1;
          beat_eop   = 1'b1;
          beat_empty = eop_empty(0, hold_empty_q);
          beat_ch    = ch_q;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      for (int k = 0; k < RATIO - 1; k++) begin
        acc_q[k] <= '0;
      end
      ch_q         <= '0;
      first_q      <= 1'b0;
      hold_empty_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      ch_q         <= ch_d;
      first_q      <= first_d;
      hold_empty_q <= hold_empty_d;
      err_q        <= err_d;
    end
  end

  ast_width_upsizer_out_reg #(
    .DATA_W    (DATA_OUT_W),
    .EMPTY_W   (EMPTY_OUT_W),
    .CHANNEL_W (CHANNEL_W)
  ) u_out_reg (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (load),
    .ready_i   (ast_ready_i),
    .data_i    (beat_data),
    .sop_i     (beat_sop),
    .eop_i     (beat_eop),
    .empty_i   (beat_empty),
    .channel_i (beat_ch),
    .valid_o   (ast_valid_o),
    .data_o    (ast_data_o),
    .sop_o     (ast_startofpacket_o),
    .eop_o     (ast_endofpacket_o),
    .empty_o   (ast_empty_o),
    .channel_o (ast_channel_o)
  );

endmodule

// File: doc/ast_width_upsizer.md
Name: ast_width_upsizer

Overview:
- Avalon-ST packet width upsizer: packs RATIO = DATA_OUT_W/DATA_IN_W input words into one output beat.
- Carries sop/eop, empty and channel, with full ready/valid backpressure on both sides.
- Generalises the fixed 64->128 converter to any integer ratio ≥2.
- Adds recovery from framing errors (missing sop, missing eop) with an error pulse.

Parameters:
- DATA_IN_W, 64, input data width in bits; multiple of 8.
- DATA_OUT_W, 128, output data width in bits; integer multiple ≥2 of DATA_IN_W (elaboration-time assertion).
- CHANNEL_W, 10, channel field width.
- EMPTY_IN_W, max(clog2(DATA_IN_W/8),1), derived, input empty width.
- EMPTY_OUT_W, max(clog2(DATA_OUT_W/8),1), derived, output empty width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- ast_data_i  in  DATA_IN_W  input word.
- ast_startofpacket_i  in  1  first word of packet.
- ast_endofpacket_i  in  1  last word of packet.
- ast_valid_i  in  1  input word valid.
- ast_empty_i  in  EMPTY_IN_W  unused bytes in eop word; ignored when eop=0.
- ast_channel_i  in  CHANNEL_W  channel; sampled only on sop words.
- ast_ready_o  out  1  input accept.
- ast_data_o  out  DATA_OUT_W  output beat.
- ast_startofpacket_o  out  1  first beat of packet.
- ast_endofpacket_o  out  1  last beat of packet.
- ast_valid_o  out  1  output beat valid.
- ast_empty_o  out  EMPTY_OUT_W  unused bytes in eop beat.
- ast_channel_o  out  CHANNEL_W  packet channel.
- ast_ready_i  in  1  downstream accept.
- err_o  out  1  one-cycle pulse on a framing error.

Behaviour:
- **Handshake**
  - Input transfer occurs when ast_valid_i & ast_ready_o.
  - Output transfer occurs when ast_valid_o & ast_ready_i.
  - Output register loads only when out_free = !ast_valid_o | ast_ready_i.
  - Output signals are held stable while ast_valid_o=1 and ast_ready_i=0.
  - ast_ready_o = out_free & (state != HOLD) & rst_ni, with no dependence on input data.
- **Packing**
  - Word k (0..RATIO-1) of a beat occupies bits [DATA_OUT_W-1-k*DATA_IN_W -: DATA_IN_W], so the first word is most significant.
  - Unfilled lanes are driven to 0.
  - Accumulator holds up to RATIO-1 words plus index idx.
  - Accepting word idx=RATIO-1, or any eop word, loads the output register in the same cycle. Output latency is 1 cycle.
- **Empty**
  - On the eop beat: ast_empty_o = (RATIO-1-k_eop)*DATA_IN_W/8 + ast_empty_i.
  - On non-eop beats: ast_empty_o = 0.
- **sop/eop and channel**
  - ast_startofpacket_o is set only on the first beat of a packet.
  - ast_channel_o is latched from the sop word and held for the whole packet.
- **FSM**
  - IDLE (no open packet):
    - sop&!eop word -> PKT, idx=1, or beat emitted immediately when RATIO... (n/a, RATIO≥2).
    - sop&eop word -> beat emitted, stay IDLE.
    - Word without sop -> dropped, err_o pulse, stay IDLE.
  - PKT (open packet):
    - Non-sop word -> accumulate, or emit on completion/eop.
    - eop -> IDLE.
    - sop word (missing eop): partial beat emitted with eop=1, empty computed from idx-1 and ast_empty_o's input term = 0; err_o pulse.
      - New word starts a packet at idx=1, stay PKT.
      - If that new word also has eop, it is stored and state -> HOLD.
  - HOLD (completed single-word beat waiting):
    - ast_ready_o=0.
    - When out_free, emit it (sop=eop=1) -> IDLE.
- **Ratio boundaries**
  - Beat completion with idx wrap: after emitting a full beat, idx returns to 0 and state stays PKT.
  - Downstream stall never loses or reorders words. The upstream is throttled through ast_ready_o.
- **Reset (async, any time, including mid-packet)**
  - Partial packet discarded.
  - State -> IDLE, idx=0.
  - Outputs: ast_valid_o=0, data/empty/channel/sop/eop=0, err_o=0, ast_ready_o=0 while asserted and 1 in the first cycle after release.

Decomposition:
- Shared package `usr_types_and_params`:
  - Add RATIO constant.
  - Add state enum {IDLE, PKT, HOLD}.
  - Reuse channel_t, empty_in_t, empty_out_t.
- Optional sub-module ast_upsizer_out_reg: output holding register with load/stall logic. Everything else stays in the top module.

Test Plan:
1. 64->128, 4-word packet (channel 5, ast_empty_i=3 on last word), ready_i=1 -> two beats:
   - {w0,w1} sop=1, channel=5.
   - {w2,w3} eop=1, empty=3.
2. 3-word packet, ast_empty_i=2 -> second beat {w2,64'h0}, eop=1, empty=10.
3. Single-word sop&eop, ast_empty_i=1 -> one beat {w0,64'h0}, sop=eop=1, empty=9.
4. ast_ready_i low for 5 cycles mid-stream -> ast_ready_o=0 after the output fills; ast_data_o stable; all 8 words of a 2-packet stream arrive intact and in order.
5. sop after 1 word of an open packet -> flushed beat {w0,0}, eop=1, empty=8, err_o pulse; the following 2-word packet is emitted normally.
6. Non-sop word in IDLE -> no output, err_o pulse. Then rst_ni low mid-packet with 1 word held -> all outputs 0; the next packet is unaffected.
7. Repeat scenarios 1–5 at DATA_OUT_W=256 (RATIO=4).
